// File: rtl/rggen_trigger_handshake_pkg.sv
// Shared types for the trigger-bit handshake consumer.
// Holds the per-channel state encoding and the timeout counter sizing rule.
package rggen_trigger_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        CLEAR,
        RELEASE
    } rggen_trigger_handshake_state_e;

    // Counter must hold 0..TIMEOUT-1; a disabled timeout still gets a 1-bit counter.
    function automatic int cnt_width(input int timeout);
        int w;
        w = (timeout > 0) ? $clog2(timeout + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rggen_trigger_handshake_channel.sv
// One trigger bit: 4-phase req/ack handshake with optional timeout,
// ending in a single-cycle clear pulse back into the bit field.
module rggen_trigger_handshake_channel
    import rggen_trigger_handshake_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic value,
    input  logic ack,
    output logic clear,
    output logic request,
    output logic busy,
    output logic timeout
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    rggen_trigger_handshake_state_e state;
    logic [CW-1:0]                  cnt;
    logic                           timed_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A stale-high ack holds off the start until it drops.
                    if (value && !ack) begin
                        state     <= REQUEST;
                        cnt       <= '0;
                        timed_out <= 1'b0;
                    end
                end
                REQUEST: begin
                    if (ack) begin
                        state <= CLEAR;
                    end else if ((TIMEOUT > 0) && (cnt == LAST)) begin
                        state     <= CLEAR;
                        timed_out <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEAR: state <= RELEASE;
                RELEASE: begin
                    if (!ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign request = (state == REQUEST);
    assign clear   = (state == CLEAR);
    assign busy    = (state != IDLE);
    assign timeout = (state == CLEAR) && timed_out;

endmodule

// File: rtl/rggen_bit_field_trigger_handshake.sv
// Consumer for software-set/hardware-clear trigger fields: one independent
// handshake channel per bit, no arbitration between channels.
module rggen_bit_field_trigger_handshake
    import rggen_trigger_handshake_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_clear,
    output logic [WIDTH-1:0] o_request,
    input  logic [WIDTH-1:0] i_ack,
    output logic [WIDTH-1:0] o_busy,
    output logic [WIDTH-1:0] o_timeout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        rggen_trigger_handshake_channel #(
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .value   (i_value[i]),
            .ack     (i_ack[i]),
            .clear   (o_clear[i]),
            .request (o_request[i]),
            .busy    (o_busy[i]),
            .timeout (o_timeout[i])
        );
    end

endmodule

// File: tb/tb_rggen_bit_field_trigger_handshake.sv
// Directed bench: a 4-channel no-timeout instance and a 1-channel TIMEOUT=4
// instance, each fed by a bench-side model of a write-priority trigger field.
module tb_rggen_bit_field_trigger_handshake;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] set_a, ack_a, clr_a, req_a, busy_a, tmo_a;
    logic [3:0] fa = '0;
    logic       set_b, ack_b, clr_b, req_b, busy_b, tmo_b;
    logic       fb = 1'b0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // Trigger field: software set wins over the hardware clear; rst does not touch it.
    always @(posedge clk) begin
        fa <= (fa & ~clr_a) | set_a;
        fb <= (fb & ~clr_b) | set_b;
    end

    rggen_bit_field_trigger_handshake #(.WIDTH(4), .TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst), .i_value(fa), .o_clear(clr_a),
        .o_request(req_a), .i_ack(ack_a), .o_busy(busy_a), .o_timeout(tmo_a)
    );

    rggen_bit_field_trigger_handshake #(.WIDTH(1), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .i_value(fb), .o_clear(clr_b),
        .o_request(req_b), .i_ack(ack_b), .o_busy(busy_b), .o_timeout(tmo_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        logic [3:0] z;
        z = '0;
        rst = 1'b1;
        set_a = '0; ack_a = '0; set_b = 1'b0; ack_b = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({req_a, clr_a, busy_a, tmo_a} !== {z, z, z, z}) begin
            bad++;
            $display("FAIL reset_a got=%h want=0", {req_a, clr_a, busy_a, tmo_a});
        end
        total++;
        if ({req_b, clr_b, busy_b, tmo_b} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_b got=%b want=0000", {req_b, clr_b, busy_b, tmo_b});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] er, ec, eb, ef;
        set_a = 4'b0001;
        tick();
        for (int c = 0; c < 9; c++) begin
            er = {3'b0, (c >= 1 && c <= 3)};
            ec = {3'b0, (c == 4)};
            eb = {3'b0, (c >= 1 && c <= 6)};
            ef = {3'b0, (c <= 4)};
            total++;
            if (req_a !== er) begin bad++; $display("FAIL basic_req c=%0d got=%b want=%b", c, req_a, er); end
            total++;
            if (clr_a !== ec) begin bad++; $display("FAIL basic_clr c=%0d got=%b want=%b", c, clr_a, ec); end
            total++;
            if (busy_a !== eb) begin bad++; $display("FAIL basic_busy c=%0d got=%b want=%b", c, busy_a, eb); end
            total++;
            if (fa !== ef) begin bad++; $display("FAIL basic_field c=%0d got=%b want=%b", c, fa, ef); end
            total++;
            if (tmo_a !== 4'b0) begin bad++; $display("FAIL basic_tmo c=%0d got=%b want=0000", c, tmo_a); end
            set_a = '0;
            ack_a = {3'b0, (c >= 3 && c < 6)};
            tick();
        end
    endtask

    task automatic test_timeout();
        set_b = 1'b1;
        tick();
        for (int c = 0; c < 9; c++) begin
            total++;
            if (req_b !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL tmo_req c=%0d got=%b want=%b", c, req_b, (c >= 1 && c <= 4)); end
            total++;
            if (clr_b !== (c == 5)) begin bad++; $display("FAIL tmo_clr c=%0d got=%b want=%b", c, clr_b, (c == 5)); end
            total++;
            if (tmo_b !== (c == 5)) begin bad++; $display("FAIL tmo_pulse c=%0d got=%b want=%b", c, tmo_b, (c == 5)); end
            total++;
            if (busy_b !== (c >= 1 && c <= 6)) begin bad++; $display("FAIL tmo_busy c=%0d got=%b want=%b", c, busy_b, (c >= 1 && c <= 6)); end
            total++;
            if (fb !== (c <= 5)) begin bad++; $display("FAIL tmo_field c=%0d got=%b want=%b", c, fb, (c <= 5)); end
            set_b = 1'b0;
            tick();
        end
    endtask

    task automatic test_retrigger();
        int clears;
        logic er, eb;
        clears = 0;
        set_a = 4'b0001;
        tick();
        for (int c = 0; c < 15; c++) begin
            er = (c >= 1 && c <= 3) || (c >= 7 && c <= 9);
            eb = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
            if (clr_a[0]) clears++;
            total++;
            if (req_a[0] !== er) begin bad++; $display("FAIL retrig_req c=%0d got=%b want=%b", c, req_a[0], er); end
            total++;
            if (busy_a[0] !== eb) begin bad++; $display("FAIL retrig_busy c=%0d got=%b want=%b", c, busy_a[0], eb); end
            if (c == 5 || c == 6) begin
                total++;
                if (fa[0] !== 1'b1) begin bad++; $display("FAIL retrig_field_kept c=%0d got=%b want=1", c, fa[0]); end
            end
            set_a = (c == 4) ? 4'b0001 : 4'b0000;
            ack_a = {3'b0, (c >= 3 && c < 5) || (c >= 9 && c < 11)};
            tick();
        end
        total++;
        if (clears != 2) begin bad++; $display("FAIL retrig_clear_count got=%0d want=2", clears); end
        total++;
        if (fa[0] !== 1'b0) begin bad++; $display("FAIL retrig_field_end got=%b want=0", fa[0]); end
    endtask

    task automatic test_stale_ack();
        set_a = 4'b0010;
        ack_a = 4'b0010;
        tick();
        for (int c = 0; c < 12; c++) begin
            total++;
            if (req_a[1] !== (c >= 5 && c <= 7)) begin bad++; $display("FAIL stale_req c=%0d got=%b want=%b", c, req_a[1], (c >= 5 && c <= 7)); end
            total++;
            if (clr_a[1] !== (c == 8)) begin bad++; $display("FAIL stale_clr c=%0d got=%b want=%b", c, clr_a[1], (c == 8)); end
            total++;
            if (busy_a[1] !== (c >= 5 && c <= 9)) begin bad++; $display("FAIL stale_busy c=%0d got=%b want=%b", c, busy_a[1], (c >= 5 && c <= 9)); end
            set_a = '0;
            ack_a = {2'b0, (c < 4) || (c >= 7 && c < 9), 1'b0};
            tick();
        end
    endtask

    task automatic test_independent();
        logic [3:0] er, ec, eb;
        set_a = 4'b0101;
        tick();
        for (int c = 0; c < 10; c++) begin
            er = {1'b0, (c >= 1 && c <= 2), 1'b0, (c >= 1 && c <= 5)};
            ec = (c == 3) ? 4'b0100 : (c == 6) ? 4'b0001 : 4'b0000;
            eb = {1'b0, (c >= 1 && c <= 4), 1'b0, (c >= 1 && c <= 7)};
            total++;
            if (req_a !== er) begin bad++; $display("FAIL indep_req c=%0d got=%b want=%b", c, req_a, er); end
            total++;
            if (clr_a !== ec) begin bad++; $display("FAIL indep_clr c=%0d got=%b want=%b", c, clr_a, ec); end
            total++;
            if (busy_a !== eb) begin bad++; $display("FAIL indep_busy c=%0d got=%b want=%b", c, busy_a, eb); end
            set_a = '0;
            ack_a = {1'b0, (c >= 2 && c < 4), 1'b0, (c >= 5 && c < 7)};
            tick();
        end
    endtask

    task automatic test_reset();
        logic er, eb;
        set_a = 4'b0001;
        tick();
        for (int c = 0; c < 13; c++) begin
            er = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
            eb = (c >= 1 && c <= 3) || (c >= 6 && c <= 10);
            total++;
            if (req_a[0] !== er) begin bad++; $display("FAIL rst_req c=%0d got=%b want=%b", c, req_a[0], er); end
            total++;
            if (clr_a[0] !== (c == 9)) begin bad++; $display("FAIL rst_clr c=%0d got=%b want=%b", c, clr_a[0], (c == 9)); end
            total++;
            if (busy_a[0] !== eb) begin bad++; $display("FAIL rst_busy c=%0d got=%b want=%b", c, busy_a[0], eb); end
            if (c == 4) begin
                total++;
                if ({req_a, clr_a, busy_a, tmo_a} !== 16'h0) begin bad++; $display("FAIL rst_all_zero got=%h want=0000", {req_a, clr_a, busy_a, tmo_a}); end
            end
            set_a = '0;
            rst   = (c == 3 || c == 4);
            ack_a = {3'b0, (c >= 8 && c < 10)};
            tick();
        end
    endtask

    initial begin
        test_reset_state();
        test_basic();
        test_timeout();
        test_retrigger();
        test_stale_ack();
        test_independent();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
